// File: rtl/uart_transmit.sv
// ----------------------------------------------------------------------------
// uart_transmit
//   Serialises one byte at a time onto a UART line: start bit, 8 data bits
//   LSB first, optional even parity bit, one stop bit. Bit time is a fixed
//   number of clk cycles (CLKS_PER_BIT).
//
//   Optional feature macro: UART_TX_PARITY_EN
//     undefined -> 8N1, 10-bit frame
//     defined   -> 8E1, 11-bit frame, PARITY state between DATA and STOP
//
// Ports
//   clk        in   system clock, all state on posedge
//   reset      in   asynchronous, active-high reset
//   dataIn     in   byte to send, sampled only on an accept cycle
//   dataValid  in   upstream offers dataIn
//   ready      out  1 = idle; a byte is accepted at this edge if dataValid=1
//   txd        out  serial line, idles high
//   txDone     out  1-cycle pulse on the last cycle of the stop bit
//   state_dbg  out  current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//
// Handshake: a transfer happens on a posedge where ready=1 and dataValid=1.
//   ready is high exactly while the FSM is idle. dataValid seen while ready=0
//   has no effect and is not remembered; upstream keeps it high until ready=1.
// ----------------------------------------------------------------------------
module uart_transmit #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dataIn,
    input  logic       dataValid,
    output logic       ready,
    output logic       txd,
    output logic       txDone,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift_byte, shift_byte_n;
    logic        txd_n, ready_n, tx_done_n;
    logic        baud_end;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign state_dbg = state;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= 16'd0;
            bit_idx    <= 3'd0;
            shift_byte <= 8'd0;
            txd        <= 1'b1;
            ready      <= 1'b1;
            txDone     <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            shift_byte <= shift_byte_n;
            txd        <= txd_n;
            ready      <= ready_n;
            txDone     <= tx_done_n;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt;
        bit_idx_n    = bit_idx;
        shift_byte_n = shift_byte;
        case (state)
            S_IDLE: begin
                if (dataValid) begin
                    state_n      = S_START;
                    baud_cnt_n   = 16'd0;
                    bit_idx_n    = 3'd0;
                    shift_byte_n = dataIn;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_n    = S_DATA;
                    baud_cnt_n = 16'd0;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_cnt_n = 16'd0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_n    = S_STOP;
                    baud_cnt_n = 16'd0;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    state_n    = S_IDLE;
                    baud_cnt_n = 16'd0;
                end else begin
                    baud_cnt_n = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_n    = S_IDLE;
                baud_cnt_n = 16'd0;
                bit_idx_n  = 3'd0;
            end
        endcase
    end

    // Outputs are registered: their next values are decoded from the next
    // state so txd/ready/txDone line up with the state they describe.
    always_comb begin
        txd_n     = 1'b1;
        ready_n   = 1'b0;
        tx_done_n = 1'b0;
        case (state_n)
            S_IDLE:   ready_n = 1'b1;
            S_START:  txd_n   = 1'b0;
            S_DATA:   txd_n   = shift_byte_n[bit_idx_n];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_n   = ^shift_byte_n;
`endif
            S_STOP: begin
                txd_n     = 1'b1;
                tx_done_n = (baud_cnt_n == BAUD_LAST);
            end
            default:  txd_n   = 1'b1;
        endcase
    end

endmodule
